// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-port memory arbiter: state encoding,
// port indices and request-bus packing width.
package mem_arb_pkg;

    localparam int PORT_DATA  = 0;
    localparam int PORT_FETCH = 1;
    localparam int PORT_DMA   = 2;
    localparam int NPORTS     = PORT_DMA + 1;
    localparam int BUS_W      = 16;
    localparam int AGE_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller signals of the arbiter; slave is the
// arbiter's view, master is the view of whatever drives requests and memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS-1:0]       req_we;
    logic [NPORTS-1:0]       req_instr;
    logic [NPORTS*BUS_W-1:0] req_addr;
    logic [NPORTS*BUS_W-1:0] req_wdata;
    logic [NPORTS-1:0]       req_grant;
    logic [NPORTS-1:0]       resp_valid;
    logic                    resp_err;
    logic [BUS_W-1:0]        resp_data;

    logic                    mem_read;
    logic                    mem_write;
    logic [BUS_W-1:0]        mem_addr;
    logic [BUS_W-1:0]        mem_wdata;
    logic                    mem_instr_access;
    logic                    mem_read_done;
    logic                    mem_busy;
    logic                    mem_ready;
    logic [BUS_W-1:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_instr, req_addr, req_wdata,
        input  mem_busy, mem_ready, mem_rdata,
        output req_grant, resp_valid, resp_err, resp_data,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_instr_access, mem_read_done
    );

    modport master (
        output req_valid, req_we, req_instr, req_addr, req_wdata,
        output mem_busy, mem_ready, mem_rdata,
        input  req_grant, resp_valid, resp_err, resp_data,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_instr_access, mem_read_done
    );

endinterface

// File: rtl/mem_arbiter_prio_age.sv
// Fixed-priority winner select with per-port starve counters; a port that has
// lost STARVE_LIMIT arbitrations in a row jumps ahead of the fixed order.
module arb_prio_age
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_valid,
    input  logic              arb_en,
    output logic [NPORTS-1:0] winner
);

    logic [NPORTS-1:0][AGE_W-1:0] age_q, age_d;
    logic [NPORTS-1:0]            starved;
    logic                         found;

    always_comb begin
        starved = '0;
        winner  = '0;
        found   = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            starved[i] = req_valid[i] && (int'(age_q[i]) >= STARVE_LIMIT);
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && starved[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req_valid[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // A withdrawn request forfeits its accumulated age immediately.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NPORTS; i++) begin
            if (!req_valid[i]) begin
                age_d[i] = '0;
            end else if (arb_en) begin
                if (winner[i])
                    age_d[i] = '0;
                else if (age_q[i] != '1)
                    age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            age_q <= '0;
        else
            age_q <= age_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Request/grant/response sequencer sharing one memory port between CPU data,
// instruction fetch and DMA requesters.
//
// state    | meaning
// IDLE     | arbitrate; grant and latch the winner when memory is not busy
// ISSUE    | one-cycle mem_read / mem_write strobe
// WAIT     | wait for mem_ready, abort after TIMEOUT cycles
// DONE     | one-cycle resp_valid to the granted port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [NPORTS-1:0]   port_q, port_d;
    logic                we_q, we_d;
    logic                instr_q, instr_d;
    logic [BUS_W-1:0]    addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [BUS_W-1:0]    rdata_q, rdata_d;
    logic [NPORTS-1:0]   resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                read_done_q, read_done_d;

    logic [NPORTS-1:0]   winner;
    logic [NPORTS-1:0]   grant;
    logic                arb_en;
    logic                sel_we, sel_instr;
    logic [BUS_W-1:0]    sel_addr, sel_wdata;

    arb_prio_age #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .req_valid (bus.req_valid),
        .arb_en    (arb_en),
        .winner    (winner)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_instr = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (winner[i]) begin
                sel_we    = bus.req_we[i];
                sel_instr = bus.req_instr[i];
                sel_addr  = bus.req_addr[i*BUS_W +: BUS_W];
                sel_wdata = bus.req_wdata[i*BUS_W +: BUS_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        we_d         = we_q;
        instr_d      = instr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tmo_d        = tmo_q;
        rdata_d      = rdata_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        read_done_d  = 1'b0;
        arb_en       = 1'b0;
        grant        = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Gating with rst keeps a grant from leaking out of a reset cycle.
                if ((|bus.req_valid) && !bus.mem_busy && !rst) begin
                    arb_en  = 1'b1;
                    grant   = winner;
                    port_d  = winner;
                    we_d    = sel_we;
                    instr_d = sel_instr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rd_d    = !sel_we;
                    wr_d    = sel_we;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    if (!we_q)
                        rdata_d = bus.mem_rdata;
                    resp_valid_d = port_q;
                    read_done_d  = !we_q;
                    state_d      = ST_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    resp_valid_d = port_q;
                    resp_err_d   = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            port_q       <= '0;
            we_q         <= 1'b0;
            instr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            tmo_q        <= '0;
            rdata_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            read_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            we_q         <= we_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            tmo_q        <= tmo_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            read_done_q  <= read_done_d;
        end
    end

    assign bus.req_grant        = grant;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_err         = resp_err_q;
    assign bus.resp_data        = rdata_q;
    assign bus.mem_read         = rd_q;
    assign bus.mem_write        = wr_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.mem_instr_access = instr_q;
    assign bus.mem_read_done    = read_done_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares the external memory bus (SDRAM/RAM controller side) between three requesters: CPU data access (port 0), instruction fetch (port 1) and a DMA/peripheral master (port 2). It sits between the core and the memory controller. It replaces the ad-hoc OR of read strobes and the address mux with a registered request/grant/response sequencer. Arbitration is fixed-priority with aging, so the fetch and DMA ports cannot starve.

## Interface
- `STARVE_LIMIT`, default 8: consecutive lost arbitrations after which a waiting port is promoted to top priority.
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before the transaction is aborted with an error.

- `clk`, in, 1: single clock; every flop in the block is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 3: per-port request. It must be held until the matching `req_grant` pulse.
- `req_we`, in, 3: per-port write enable (1 = write, 0 = read).
- `req_instr`, in, 3: per-port instruction-memory space select.
- `req_addr`, in, 48: per-port address; port i is bits [16i+15:16i].
- `req_wdata`, in, 48: per-port write data, same packing as `req_addr`.
- `req_grant`, out, 3: one-hot, one-cycle pulse. The request has been captured and may be dropped.
- `resp_valid`, out, 3: one-hot, one-cycle pulse. Marks read data or write completion.
- `resp_err`, out, 1: qualifies `resp_valid`; high when the transaction timed out.
- `resp_data`, out, 16: read data, valid while `resp_valid` is nonzero.
- `mem_read`, out, 1: one-cycle memory read strobe.
- `mem_write`, out, 1: one-cycle memory write strobe.
- `mem_addr`, out, 16: registered address.
- `mem_wdata`, out, 16: registered write data.
- `mem_instr_access`, out, 1: registered `req_instr` of the winning port.
- `mem_read_done`, out, 1: one-cycle acknowledge to the controller that the data has been consumed.
- `mem_busy`, in, 1: memory controller busy.
- `mem_ready`, in, 1: memory controller read data valid or write complete.
- `mem_rdata`, in, 16: memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**: when any `req_valid` bit is set and `mem_busy`=0, select the winner and latch its address, data, we and instr. Pulse `req_grant[w]` in this same cycle, then go to ISSUE. If `mem_busy`=1, stay in IDLE and issue no grant.
- **Priority**:
  - Any port whose starve counter is at or above `STARVE_LIMIT` wins. If several are, the lowest index wins.
  - Otherwise port 0 beats port 1, and port 1 beats port 2.
- **Starve counters**: 4 bits per port, saturating.
  - On every arbitration, each requesting port that loses increments its counter.
  - The winner's counter clears.
  - A port that is not requesting clears its counter.
- **ISSUE**: assert `mem_read` or `mem_write` for exactly one cycle, then go to WAIT. The timeout counter clears.
- **WAIT**: counts cycles. On `mem_ready`, capture `mem_rdata` and go to DONE. When the counter reaches `TIMEOUT`, go to DONE with the error flag set.
- **DONE**: pulse `resp_valid[w]` for one cycle.
  - For a read, `resp_data` equals the captured data.
  - `resp_err` equals the error flag.
  - `mem_read_done` pulses in the same cycle for non-error reads.
  - Return to IDLE.
- `mem_ready` seen in IDLE, ISSUE or DONE is ignored. It is never forwarded to a requester.
- A request withdrawn before its grant is legal and is never issued.
- `mem_addr`, `mem_wdata` and `mem_instr_access` hold their value from the grant until the next grant.

## Timing
- Reset: state goes to IDLE and all outputs drive 0: `req_grant`, `resp_valid`, `resp_err`, `resp_data`, `mem_*` outputs. Starve and timeout counters clear. A reset during WAIT abandons the transaction with no response.
- Minimum read latency, counting request at cycle 0:
  - grant at 0;
  - `mem_read` at 1;
  - `mem_ready` no earlier than 2;
  - `resp_valid` one cycle after `mem_ready`.
- Back-to-back: the next grant can occur in the cycle after DONE, so the best-case issue rate is one transaction per 4 cycles.
- `resp_data` is a registered output and is not combinational from `mem_rdata`.
- A request and `rst` in the same cycle: reset wins and no grant is issued.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE/ISSUE/WAIT/DONE);
  - port index constants (`PORT_DATA`=0, `PORT_FETCH`=1, `PORT_DMA`=2);
  - the request-bus packing width of 16.
- One sub-module, `arb_prio_age`: the combinational winner select plus the starve-counter registers. It takes `req_valid` and an `arb_en` strobe, and outputs the one-hot winner.

## Test plan
- **Single read**: port 1 reads `0x0040`, memory returns `0xBEEF` 3 cycles after `mem_read`.
  - `req_grant`=010 at cycle 0, `mem_read` at cycle 1.
  - `resp_valid`=010 with `resp_data`=`0xBEEF` and `mem_read_done`=1.
- **Contention**: ports 0 and 2 request together. Port 0 is granted first, then port 2 in the cycle after port 0's DONE, with no overlap of memory strobes.
- **Aging**: port 0 requests continuously and port 2 is held high.
  - Port 2 wins the arbitration immediately after losing `STARVE_LIMIT` (8) times.
  - Its counter is then 0.
- **Timeout**: port 0 writes `0x1234` to `0x0100`, and `mem_ready` is never raised.
  - After 255 WAIT cycles: `resp_valid`=001, `resp_err`=1, `mem_read_done`=0.
  - The next request proceeds normally.
- **Busy and reset**: a request arrives while `mem_busy`=1, so no grant is issued until busy falls.
  - Assert `rst` during WAIT: all outputs are 0 next cycle.
  - A late `mem_ready` then produces no `resp_valid`.
